multicycle_ctrl: RTL

//  Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath (shared ALU, single memory port,
//  IR/A/B/ALUOut holding regs). Sits between instruction register and datapath muxes.

---
 rtl/multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle MIPS datapath (shared ALU,
// single memory port). Sequences fetch/decode/execute and tolerates memory
// wait states through a mem_ready handshake, with a bus-error timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leave IDLE and begin fetching (ignored elsewhere)
//   opcode              IR[31:26]
//   zero                ALU zero flag (current cycle)
//   mem_ready           memory completes the current access this cycle
//   mem_req/mem_read/mem_write/iord      memory port controls
//   ir_write, pc_en, pc_source           IR / PC update controls
//   reg_write, reg_dst, mem_to_reg       register file controls
//   alu_src_a, alu_src_b, alu_op         ALU operand / operation select
//   state, halted, bus_err               debug state, halt flag, timeout pulse
//
// Build option: define MC_PERF_CNT_EN to add the cyc_cnt / instr_cnt
// saturating performance counters (CNT_W bits wide).
//
// ir_write, pc_en, bus_err and the FETCH increment of alu_src_b depend on
// mem_ready/zero in the current cycle, so they are gated combinationally from
// registered state. Every other control output is registered.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
`ifdef MC_PERF_CNT_EN
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`else
  output logic             bus_err
`endif
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  state_e              state_q, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_nxt;
  ctrl_t               ctrl_q, ctrl_nxt;
  logic                wait_st_c;
  logic                timeout_c;
  logic                fetch_done_c;

  // Moore control word for each state; unlisted fields stay 0.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_HALT:   c.halted    = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  // Memory-access states where the FSM may stall on mem_ready.
  assign wait_st_c    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Ready wins in the timeout cycle.
  assign timeout_c    = wait_st_c && !mem_ready && (wait_cnt_q == WAIT_W'(TIMEOUT));
  assign fetch_done_c = (state_q == S_FETCH) && mem_ready;

  // Next-state, wait counter and next control word.
  always_comb begin
    state_nxt    = state_q;
    wait_cnt_nxt = '0;
    case (state_q)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_nxt = S_DECODE;
        else if (timeout_c) state_nxt = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = S_HALT;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      state_nxt = S_MEMWB;
        else if (timeout_c) state_nxt = S_HALT;
      end
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)      state_nxt = S_FETCH;
        else if (timeout_c) state_nxt = S_HALT;
      end
      S_EXEC:   state_nxt = S_RWB;
      S_RWB:    state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
    // Count stalled cycles; any exit (or completion) clears the counter.
    if (wait_st_c && !mem_ready && !timeout_c)
      wait_cnt_nxt = wait_cnt_q + WAIT_W'(1);
    ctrl_nxt = decode_ctrl(state_nxt);
  end

  // State, wait counter and registered control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      wait_cnt_q <= wait_cnt_nxt;
      ctrl_q     <= ctrl_nxt;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign iord       = ctrl_q.iord;
  assign pc_source  = ctrl_q.pc_source;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_op     = ctrl_q.alu_op;
  assign halted     = ctrl_q.halted;
  assign state      = state_q;

  // Fetch completion loads IR and PC+4 in the same cycle.
  assign ir_write  = fetch_done_c;
  assign alu_src_b = ctrl_q.alu_src_b | (fetch_done_c ? 2'b01 : 2'b00);
  assign pc_en     = ctrl_q.pc_write | fetch_done_c | (ctrl_q.pc_write_cond & zero);
  assign bus_err   = timeout_c;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, instr_q;
  logic             cyc_inc_c, instr_inc_c;

  assign cyc_inc_c   = (state_q != S_IDLE) && (state_q != S_HALT) && (cyc_q != '1);
  // A completing state hands back to FETCH; IDLE start and FETCH stalls do not count.
  assign instr_inc_c = (state_nxt == S_FETCH) && (state_q != S_IDLE) &&
                       (state_q != S_FETCH) && (instr_q != '1);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (cyc_inc_c)   cyc_q   <= cyc_q + CNT_W'(1);
      if (instr_inc_c) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`endif

endmodule
